// File: rtl/bsg_fpu_f2i_pipe_pkg.sv
// Shared FPU types and helpers for the float-to-integer pipeline.
package bsg_fpu_pkg;

   typedef enum logic [0:0] {eRTZ = 1'b0, eRNE = 1'b1} bsg_fpu_rm_e;

   function automatic int bias_f(input int e);
      return (1 << (e - 1)) - 1;
   endfunction

   // Largest unbiased exponent whose value can still fit a width-bit integer field.
   function automatic int max_ue_f(input int width);
      return width - 1;
   endfunction

endpackage

// File: rtl/bsg_fpu_f2i_pipe_if.sv
// Ready/valid bundle between the issue queue, the converter and the writeback arbiter.
interface bsg_fpu_f2i_pipe_if #(
   parameter int e_p     = 5,
   parameter int m_p     = 10,
   parameter int width_p = 16
);
   import bsg_fpu_pkg::*;

   logic               v_i;
   logic               ready_o;
   logic [e_p+m_p:0]   a_i;
   logic               signed_i;
   bsg_fpu_rm_e        rm_i;
   logic               v_o;
   logic               yumi_i;
   logic [width_p-1:0] z_o;
   logic               invalid_o;
   logic               inexact_o;

   modport master (output v_i, a_i, signed_i, rm_i, yumi_i,
                   input  ready_o, v_o, z_o, invalid_o, inexact_o);
   modport slave  (input  v_i, a_i, signed_i, rm_i, yumi_i,
                   output ready_o, v_o, z_o, invalid_o, inexact_o);
endinterface

// File: rtl/bsg_fpu_preprocess.sv
// Splits a float into fields and classifies it as zero, denormal, infinity or NaN.
module bsg_fpu_preprocess #(
   parameter int e_p = 5,
   parameter int m_p = 10
) (
   input  logic [e_p+m_p:0] a,
   output logic             zero,
   output logic             nan,
   output logic             infty,
   output logic             denormal,
   output logic             sign,
   output logic [e_p-1:0]   exp,
   output logic [m_p-1:0]   man
);
   logic exp_zero, exp_ones, man_zero;

   assign sign     = a[e_p+m_p];
   assign exp      = a[e_p+m_p-1:m_p];
   assign man      = a[m_p-1:0];
   assign exp_zero = (exp == '0);
   assign exp_ones = (exp == '1);
   assign man_zero = (man == '0);

   assign zero     = exp_zero & man_zero;
   assign denormal = exp_zero & ~man_zero;
   assign infty    = exp_ones & man_zero;
   assign nan      = exp_ones & ~man_zero;
endmodule

// File: rtl/bsg_fpu_f2i_pipe.sv
// Two-stage float-to-integer converter: S1 classifies and aligns, S2 rounds and saturates.
module bsg_fpu_f2i_pipe
   import bsg_fpu_pkg::*;
#(
   parameter int e_p     = 5,
   parameter int m_p     = 10,
   parameter int width_p = 16
) (
   input logic                clk_i,
   input logic                reset_i,
   bsg_fpu_f2i_pipe_if.slave  io
);
   localparam int fw_lp   = m_p + width_p + 2;
   localparam int bias_lp = bias_f(e_p);
   localparam logic [width_p-1:0] max_pos_lp = {1'b0, {(width_p-1){1'b1}}};
   localparam logic [width_p-1:0] min_neg_lp = {1'b1, {(width_p-1){1'b0}}};

   typedef struct packed {
      logic               nan;
      logic               infty;
      logic               ovf;
      logic               sign;
      logic               is_signed;
      bsg_fpu_rm_e        rm;
      logic [width_p-1:0] mag;
      logic               guard;
      logic               sticky;
   } s1_t;

   logic             zero, nan, infty, denormal, sign;
   logic [e_p-1:0]   exp;
   logic [m_p-1:0]   man;
   logic signed [e_p+1:0] sh;
   logic [fw_lp-1:0] field;
   s1_t              s1_n, s1_r;
   logic             s1_v, v_r, s1_adv, s2_adv;

   bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) pre (
      .a(io.a_i), .zero, .nan, .infty, .denormal, .sign, .exp, .man
   );

   // sh = unbiased exponent + 2, so the two bits below the binary point land at m_p+1 (guard)
   // and below it (sticky) for every exponent from -2 upward.
   always_comb begin
      sh    = $signed({2'b00, exp}) - $signed((e_p+2)'(bias_lp - 2));
      field = fw_lp'({1'b1, man}) << $unsigned(sh);
      s1_n  = '0;
      s1_n.nan       = nan;
      s1_n.infty     = infty;
      s1_n.sign      = sign;
      s1_n.is_signed = io.signed_i;
      s1_n.rm        = io.rm_i;
      if (zero) begin
         s1_n.sticky = 1'b0;
      end else if (denormal | sh[e_p+1]) begin
         s1_n.sticky = 1'b1;
      end else if (sh > $signed((e_p+2)'(max_ue_f(width_p) + 2))) begin
         s1_n.ovf = 1'b1;
      end else begin
         s1_n.mag    = field[fw_lp-1 -: width_p];
         s1_n.guard  = field[m_p+1];
         s1_n.sticky = |field[m_p:0];
      end
   end

   logic               inc, range_ovf, ovf, neg;
   logic [width_p:0]   rmag;
   logic [width_p-1:0] z_n, z_r;
   logic               invalid_n, inexact_n, invalid_r, inexact_r;

   always_comb begin
      inc  = (s1_r.rm == eRNE) & s1_r.guard & (s1_r.sticky | s1_r.mag[0]);
      rmag = {1'b0, s1_r.mag} + (width_p+1)'(inc);
      neg  = s1_r.sign;
      if (!s1_r.is_signed)
         range_ovf = rmag[width_p];
      else if (!neg)
         range_ovf = |rmag[width_p:width_p-1];
      else
         range_ovf = rmag[width_p] | (rmag[width_p-1] & |rmag[width_p-2:0]);
      ovf       = range_ovf | s1_r.ovf | s1_r.infty;
      z_n       = '0;
      invalid_n = 1'b0;
      inexact_n = 1'b0;
      if (s1_r.nan || (ovf && !neg)) begin
         invalid_n = 1'b1;
         z_n       = s1_r.is_signed ? max_pos_lp : '1;
      end else if (ovf && s1_r.is_signed) begin
         invalid_n = 1'b1;
         z_n       = min_neg_lp;
      end else if (neg && !s1_r.is_signed && (ovf || rmag != '0)) begin
         invalid_n = 1'b1;
      end else begin
         z_n       = (neg && s1_r.is_signed) ? -rmag[width_p-1:0] : rmag[width_p-1:0];
         inexact_n = s1_r.guard | s1_r.sticky;
      end
   end

   assign s2_adv     = ~v_r | io.yumi_i;
   assign s1_adv     = ~s1_v | s2_adv;
   assign io.ready_o = s1_adv;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_v <= 1'b0;
         v_r  <= 1'b0;
      end else begin
         if (s1_adv) s1_v <= io.v_i;
         if (s2_adv) v_r  <= s1_v;
      end
   end

   // NOTE: datapath registers carry no reset; the valid bits alone decide whether they mean anything.
   always_ff @(posedge clk_i) begin
      if (s1_adv && io.v_i) s1_r <= s1_n;
      if (s2_adv && s1_v) begin
         z_r       <= z_n;
         invalid_r <= invalid_n;
         inexact_r <= inexact_n;
      end
   end

   assign io.v_o       = v_r;
   assign io.z_o       = z_r;
   assign io.invalid_o = invalid_r;
   assign io.inexact_o = inexact_r;
endmodule

// File: tb/tb_bsg_fpu_f2i_pipe.sv
// Scoreboard bench for the float-to-integer pipeline (half->16 and single->32 instances).
module tb_bsg_fpu_f2i_pipe;
   import bsg_fpu_pkg::*;

   typedef struct {
      logic [31:0] z;
      logic [1:0]  flags;
      string       name;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic        sgn;
      logic        rm;
      logic [15:0] z;
      logic        inv;
      logic        inx;
   } vec_t;

   logic clk, reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic yumi_en = 1'b1;
   exp_t q16[$];
   exp_t q32[$];

   bsg_fpu_f2i_pipe_if #(.e_p(5), .m_p(10), .width_p(16)) io16 ();
   bsg_fpu_f2i_pipe_if #(.e_p(8), .m_p(23), .width_p(32)) io32 ();

   bsg_fpu_f2i_pipe #(.e_p(5), .m_p(10), .width_p(16)) dut16 (
      .clk_i(clk), .reset_i(reset), .io(io16)
   );
   bsg_fpu_f2i_pipe #(.e_p(8), .m_p(23), .width_p(32)) dut32 (
      .clk_i(clk), .reset_i(reset), .io(io32)
   );

   vec_t vecs [23] = '{
      '{16'h3E00, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1},
      '{16'h3E00, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1},
      '{16'h4100, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1},
      '{16'hBC00, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0},
      '{16'hBC00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
      '{16'hB400, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1},
      '{16'h7BFF, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0},
      '{16'h7BFF, 1'b0, 1'b0, 16'hFFE0, 1'b0, 1'b0},
      '{16'hFC00, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0},
      '{16'h7E00, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0},
      '{16'hF800, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0},
      '{16'h7800, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0},
      '{16'h0001, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1},
      '{16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{16'h3800, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1},
      '{16'h3A00, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1},
      '{16'h3D00, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1},
      '{16'h2C00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{16'h7C00, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0},
      '{16'hFC00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h7E00, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0},
      '{16'h4300, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1},
      '{16'hC300, 1'b1, 1'b1, 16'hFFFC, 1'b0, 1'b1}
   };

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic send16(input logic [15:0] a, input logic sgn, input logic rm,
                         input logic [15:0] z, input logic inv, input logic inx, input string name);
      exp_t e;
      int   waits;
      waits = 0;
      @(negedge clk);
      io16.v_i = 1'b1; io16.a_i = a; io16.signed_i = sgn; io16.rm_i = bsg_fpu_rm_e'(rm);
      #1;
      while (!io16.ready_o && waits < 40) begin
         @(negedge clk); #1;
         waits++;
      end
      if (!io16.ready_o) begin
         check({name, "_ready"}, 32'(io16.ready_o), 32'd1);
         io16.v_i = 1'b0;
         return;
      end
      e.z = {16'h0, z}; e.flags = {inv, inx}; e.name = name;
      q16.push_back(e);
      @(posedge clk); #1;
      io16.v_i = 1'b0;
   endtask

   task automatic send32(input logic [31:0] a, input logic sgn, input logic rm,
                         input logic [31:0] z, input logic inv, input logic inx, input string name);
      exp_t e;
      int   waits;
      waits = 0;
      @(negedge clk);
      io32.v_i = 1'b1; io32.a_i = a; io32.signed_i = sgn; io32.rm_i = bsg_fpu_rm_e'(rm);
      #1;
      while (!io32.ready_o && waits < 40) begin
         @(negedge clk); #1;
         waits++;
      end
      if (!io32.ready_o) begin
         check({name, "_ready"}, 32'(io32.ready_o), 32'd1);
         io32.v_i = 1'b0;
         return;
      end
      e.z = z; e.flags = {inv, inx}; e.name = name;
      q32.push_back(e);
      @(posedge clk); #1;
      io32.v_i = 1'b0;
   endtask

   initial begin : mon16
      exp_t e;
      io16.yumi_i = 1'b0;
      forever begin
         @(negedge clk);
         if (io16.v_o && yumi_en) begin
            if (q16.size() == 0) begin
               check("spurious_v_o16", 32'(io16.v_o), 32'd0);
            end else begin
               e = q16.pop_front();
               check({e.name, "_z"}, {16'h0, io16.z_o}, e.z);
               check({e.name, "_flags"}, 32'({io16.invalid_o, io16.inexact_o}), 32'(e.flags));
            end
            io16.yumi_i = 1'b1;
         end else begin
            io16.yumi_i = 1'b0;
         end
      end
   end

   initial begin : mon32
      exp_t e;
      io32.yumi_i = 1'b0;
      forever begin
         @(negedge clk);
         if (io32.v_o) begin
            if (q32.size() == 0) begin
               check("spurious_v_o32", 32'(io32.v_o), 32'd0);
            end else begin
               e = q32.pop_front();
               check({e.name, "_z"}, io32.z_o, e.z);
               check({e.name, "_flags"}, 32'({io32.invalid_o, io32.inexact_o}), 32'(e.flags));
            end
            io32.yumi_i = 1'b1;
         end else begin
            io32.yumi_i = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      reset = 1'b1;
      io16.v_i = 1'b0; io16.a_i = '0; io16.signed_i = 1'b0; io16.rm_i = eRTZ;
      io32.v_i = 1'b0; io32.a_i = '0; io32.signed_i = 1'b0; io32.rm_i = eRTZ;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_v_o", 32'(io16.v_o), 32'd0);
      check("reset_ready", 32'(io16.ready_o), 32'd1);
      check("reset_v_o32", 32'(io32.v_o), 32'd0);

      // Single op into an empty pipe: result visible in the second cycle after acceptance.
      send16(16'h3C00, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "lat");
      @(negedge clk);
      check("lat_cycle1_v_o", 32'(io16.v_o), 32'd0);
      @(negedge clk);
      check("lat_cycle2_v_o", 32'(io16.v_o), 32'd1);
      repeat (2) @(negedge clk);

      // Back-to-back directed vectors at full throughput.
      foreach (vecs[i])
         send16(vecs[i].a, vecs[i].sgn, vecs[i].rm, vecs[i].z, vecs[i].inv, vecs[i].inx,
                $sformatf("v%0d", i));
      repeat (2) @(negedge clk);
      #1;
      check("burst_drained", 32'(q16.size()), 32'd0);

      // Stall: pipe absorbs two ops, then holds the output stable.
      yumi_en = 1'b0;
      send16(16'h4300, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, "stall_a");
      send16(16'hC500, 1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b0, "stall_b");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("stall_ready", 32'(io16.ready_o), 32'd0);
         check("stall_v_o", 32'(io16.v_o), 32'd1);
         check("stall_z_stable", {16'h0, io16.z_o}, 32'h0000_0004);
      end
      yumi_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("stall_drained", 32'(q16.size()), 32'd0);

      // Reset with two ops in flight: they must vanish.
      yumi_en = 1'b0;
      send16(16'h3C00, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "rst_a");
      send16(16'h4000, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, "rst_b");
      @(negedge clk);
      reset = 1'b1;
      q16.delete();
      @(negedge clk);
      #1;
      check("midreset_v_o", 32'(io16.v_o), 32'd0);
      check("midreset_ready", 32'(io16.ready_o), 32'd1);
      reset = 1'b0;
      yumi_en = 1'b1;
      repeat (6) @(negedge clk);
      send16(16'h4200, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, "post_rst");
      repeat (3) @(negedge clk);
      #1;
      check("post_rst_drained", 32'(q16.size()), 32'd0);

      // Wide instance: single precision to 32-bit integer.
      send32(32'hCF00_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, "w32_minneg");
      send32(32'h4F00_0000, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, "w32_posovf");
      send32(32'h4F00_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, "w32_unsigned");
      send32(32'h3FC0_0000, 1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b1, "w32_rne");
      repeat (3) @(negedge clk);
      #1;
      check("w32_drained", 32'(q32.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
